// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid buffer pipeline stage with stall and flush
module pipe_skid_stage #(
    parameter int              DW       = 16,
    parameter int              CW       = 8,
    parameter logic [DW-1:0]   RST_DATA = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          stall,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [CW-1:0] in_ctrl,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] out_ctrl,
    output logic [1:0]    occ
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] main_data;
    logic [CW-1:0] main_ctrl;
    logic [DW-1:0] skid_data;
    logic [CW-1:0] skid_ctrl;
    logic          accept;
    logic          drain;

    // Handshakes are functions of held state and stall only, so in_ready never waits on out_ready.
    assign in_ready  = (state != FULL) && !stall;
    assign out_valid = (state != EMPTY) && !stall;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_data <= RST_DATA;
            main_ctrl <= '0;
            skid_data <= RST_DATA;
            skid_ctrl <= '0;
        end else if (flush) begin
            // Payload is kept so out_data still shows the last head; control is squashed.
            state     <= EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= ONE;
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (accept) begin
                        state     <= FULL;
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                    end else if (drain) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state     <= ONE;
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_data = main_data;
    assign out_ctrl = out_valid ? main_ctrl : '0;
    assign occ      = state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - self-checking bench for pipe_skid_stage
module tb_pipe_skid_stage;
    localparam int            DW   = 16;
    localparam int            CW   = 8;
    localparam logic [DW-1:0] RSTD = 16'hDEAD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          stall = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occ;

    int tests_run = 0;
    int tests_failed = 0;

    pipe_skid_stage #(.DW(DW), .CW(CW), .RST_DATA(RSTD)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occ(occ)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } entry_t;

    // Model: an ordered FIFO of at most two entries plus the last payload that was at the head.
    entry_t        q[$];
    logic [DW-1:0] last_data = RSTD;
    logic [DW-1:0] out_log[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            last_data = RSTD;
        end else if (flush) begin
            q.delete();
        end else if (!stall) begin
            int  sz;
            bit  dr;
            bit  ac;
            sz = q.size();
            dr = (sz > 0) && out_ready;
            ac = (sz < 2) && in_valid;
            if (dr) begin
                out_log.push_back(q[0].data);
                void'(q.pop_front());
            end
            if (ac) q.push_back({in_data, in_ctrl});
            if (q.size() > 0) last_data = q[0].data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic          ev;
        logic [CW-1:0] ec;
        ev = (q.size() > 0) && !stall;
        ec = ev ? q[0].ctrl : '0;
        check("model_occ", 32'(occ), 32'(q.size()));
        check("model_in_ready", 32'(in_ready), 32'((q.size() < 2) && !stall));
        check("model_out_valid", 32'(out_valid), 32'(ev));
        check("model_out_ctrl", 32'(out_ctrl), 32'(ec));
        check("model_out_data", 32'(out_data), 32'(last_data));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        step();
        in_valid = 1'b0;
    endtask

    logic [3:0] vec_tbl [16];

    initial begin
        // reset state
        step(); step();
        @(negedge clk);
        check("rst_occ", 32'(occ), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_data", 32'(out_data), 32'(RSTD));
        step();
        rst_n = 1'b1;

        // single entry latency
        out_ready = 1'b1;
        push(16'h1234, 8'hA5);
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 1);
        check("lat_data", 32'(out_data), 32'h1234);
        check("lat_ctrl", 32'(out_ctrl), 32'hA5);
        check("lat_occ", 32'(occ), 1);
        step();

        // back-to-back stream
        out_log.delete();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            in_ctrl  = 8'(i);
            step();
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 1);
            check("stream_occ", 32'(occ), 1);
        end
        in_valid = 1'b0;
        step(); step();
        check("stream_count", 32'(out_log.size()), 8);
        for (int i = 0; i < out_log.size() && i < 8; i++)
            check("stream_order", 32'(out_log[i]), 32'(i + 1));

        // fill to FULL then drain
        out_ready = 1'b0;
        push(16'h00AA, 8'h01);
        push(16'h00BB, 8'h02);
        @(negedge clk);
        check("full_occ", 32'(occ), 2);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_data", 32'(out_data), 32'h00AA);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("drain1_occ", 32'(occ), 1);
        check("drain1_data", 32'(out_data), 32'h00BB);
        step();
        @(negedge clk);
        check("drain2_occ", 32'(occ), 0);
        check("empty_keep_data", 32'(out_data), 32'h00BB);
        check("empty_ctrl", 32'(out_ctrl), 0);

        // stall while FULL
        out_ready = 1'b0;
        push(16'h0011, 8'h11);
        push(16'h0022, 8'h22);
        stall = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0099; in_ctrl = 8'h99;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 0);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_occ", 32'(occ), 2);
            check("stall_data", 32'(out_data), 32'h0011);
        end
        stall = 1'b0; in_valid = 1'b0;
        out_log.delete();
        step(); step(); step();
        check("stall_resume_n", 32'(out_log.size()), 2);
        if (out_log.size() == 2) begin
            check("stall_resume0", 32'(out_log[0]), 32'h0011);
            check("stall_resume1", 32'(out_log[1]), 32'h0022);
        end

        // flush beats stall and an offered entry
        out_ready = 1'b0;
        push(16'h0033, 8'h33);
        push(16'h0044, 8'h44);
        flush = 1'b1; stall = 1'b1; in_valid = 1'b1; in_data = 16'h0055; in_ctrl = 8'h55;
        step();
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_occ", 32'(occ), 0);
        check("flush_valid", 32'(out_valid), 0);
        check("flush_ctrl", 32'(out_ctrl), 0);
        out_log.delete();
        out_ready = 1'b1;
        step(); step(); step();
        check("flush_no_output", 32'(out_log.size()), 0);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        push(16'h0066, 8'h66);
        push(16'h0077, 8'h77);
        #2 rst_n = 1'b0;
        #1;
        check("arst_occ", 32'(occ), 0);
        check("arst_data", 32'(out_data), 32'(RSTD));
        check("arst_valid", 32'(out_valid), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(16'h0088, 8'h08);
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 1);
        check("post_rst_data", 32'(out_data), 32'h0088);
        check("post_rst_ctrl", 32'(out_ctrl), 32'h08);
        step();

        // mixed handshake vectors {in_valid, out_ready, stall, flush}
        vec_tbl = '{4'b1000, 4'b1000, 4'b0100, 4'b1110, 4'b1100, 4'b1000, 4'b0010, 4'b1100,
                    4'b0100, 4'b1001, 4'b1100, 4'b1000, 4'b1000, 4'b0110, 4'b0100, 4'b0100};
        for (int i = 0; i < 16; i++) begin
            in_valid  = vec_tbl[i][3];
            out_ready = vec_tbl[i][2];
            stall     = vec_tbl[i][1];
            flush     = vec_tbl[i][0];
            in_data   = 16'h0100 + 16'(i);
            in_ctrl   = 8'h80 + 8'(i);
            step();
        end
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DW, default 16: payload data width in bits, legal range 1..256.
REQ-002 Parameter CW, default 8: control field width in bits, legal range 1..64; control is forced to zero on any bubble or flush.
REQ-003 Parameter RST_DATA, default 0 (DW bits): reset value of the payload registers.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous squash of all held entries.
REQ-007 stall  input  1  freeze: no accept, no drain, all state held.
REQ-008 in_valid  input  1  upstream has a valid entry.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_data  input  DW  upstream payload.
REQ-011 in_ctrl  input  CW  upstream control bits (write enables, selects).
REQ-012 out_valid  output  1  head entry presented downstream.
REQ-013 out_ready  input  1  downstream takes the head entry.
REQ-014 out_data  output  DW  head payload.
REQ-015 out_ctrl  output  CW  head control bits; zero when out_valid=0.
REQ-016 occ  output  2  entries held: 0, 1 or 2.

Function
REQ-017 Storage SHALL be two entries: a main register (drives out_*) and a skid register; no combinational path from in_data/in_ctrl to out_data/out_ctrl.
REQ-018 State SHALL be encoded by occ: EMPTY=0, ONE=1, FULL=2; occ=3 unreachable.
REQ-019 in_ready SHALL equal (occ != 2) AND NOT stall, and SHALL NOT depend on out_ready.
REQ-020 out_valid SHALL equal (occ != 0) AND NOT stall.
REQ-021 accept = in_valid AND in_ready; drain = out_valid AND out_ready.
REQ-022 EMPTY: accept -> ONE, main <= in; otherwise stay EMPTY.
REQ-023 ONE: accept AND drain -> ONE, main <= in; accept only -> FULL, skid <= in; drain only -> EMPTY; neither -> hold.
REQ-024 FULL: drain -> ONE, main <= skid; otherwise hold; no accept possible.
REQ-025 Latency SHALL be one cycle from accept in EMPTY to out_valid=1 with the accepted payload.
REQ-026 Sustained throughput SHALL be one entry per cycle with out_ready held high.
REQ-027 Entries SHALL leave in acceptance order; no entry dropped or duplicated except by flush.
REQ-028 stall=1 SHALL hold occ, main, skid unchanged, regardless of in_valid/out_ready.
REQ-029 flush SHALL have priority over stall and all transfers: next cycle occ=0, out_valid=0, out_ctrl=0; any entry offered the same cycle is discarded.
REQ-030 out_data SHALL retain its last value when EMPTY (not zeroed); out_ctrl SHALL read zero when EMPTY.
REQ-031 Skid register SHALL load only on the ONE->FULL transition; main SHALL load only on the REQ-022/023/024 transitions.
REQ-032 in_data/in_ctrl SHALL be ignored when accept=0.

Reset
REQ-033 rst_n=0 SHALL immediately force occ=0, out_valid=0, out_ctrl=0, out_data=RST_DATA, skid payload=RST_DATA, skid control=0.
REQ-034 rst_n=0 SHALL abort any in-progress transfer; in_ready SHALL read 1 (stall=0) during and after reset.
REQ-035 Reset deassertion SHALL be synchronized by the instantiating level; the block SHALL accept on the first rising edge after deassertion.

Verification
REQ-036 Reset then in_valid=1, in_data=16'h1234, in_ctrl=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=16'h1234, out_ctrl=8'hA5, occ=1.
REQ-037 Stream 0x0001..0x0008 back-to-back, out_ready=1 -> outputs 0x0001..0x0008 on consecutive cycles, in_ready constantly 1, occ=1.
REQ-038 out_ready=0, push 0x00AA, 0x00BB -> occ=2, in_ready=0, out_data=0x00AA; raise out_ready -> 0x00AA then 0x00BB, occ 2->1->0.
REQ-039 occ=2, stall=1 for 3 cycles with out_ready=1 and in_valid=1 -> out_valid=0, in_ready=0, occ=2, contents unchanged; stall=0 -> drain resumes in order.
REQ-040 occ=2 with flush=1, stall=1 and in_valid=1 same cycle -> next cycle occ=0, out_valid=0, out_ctrl=0, offered entry absent from later output.
REQ-041 rst_n pulsed low mid-stream at occ=2 -> occ=0, out_data=RST_DATA without a clock edge; first entry after release appears unaltered.
